// File: rtl/led_scan_ctrl.sv
// Double-buffered 4-column LED scan controller with blank-slot anti-ghosting and frame-synchronous swap.
// Optional macro LED_SCAN_PWM_EN adds a 4-bit brightness register gating the row data.
module led_scan_ctrl #(
   parameter int DWELL_BITS = 10
) (
   input  logic       clk12MHz,
   input  logic       rst,
   input  logic       bus_we,
   input  logic [2:0] bus_addr,
   input  logic [7:0] bus_wdata,
   output logic [7:0] leds,
   output logic [3:0] lcol,
   output logic [1:0] cur_col,
   output logic       swap_pending,
   output logic       frame_done
);

   logic [7:0]            back_buf  [4];
   logic [7:0]            front_buf [4];
   logic                  enable;
   logic [1:0]            col_p0;
   logic [DWELL_BITS-1:0] cnt_p0;

   logic wr_col;
   logic wr_ctrl;
   logic swap_req;
   logic en_next;
   logic wrap;
   logic swap_done;
   logic gate;

`ifdef LED_SCAN_PWM_EN
   logic [3:0] bright;

   function automatic logic pwm_gate(input logic [3:0] c, input logic [3:0] b);
      return (c <= b);
   endfunction

   always_ff @(posedge clk12MHz or posedge rst) begin
      if (rst) begin
         bright <= 4'hF;
      end else if (bus_we && bus_addr == 3'd4) begin
         bright <= bus_wdata[3:0];
      end
   end

   assign gate = pwm_gate(cnt_p0[3:0], bright);
`else
   assign gate = 1'b1;
`endif

   always_comb begin
      wr_col    = bus_we && (bus_addr[2] == 1'b0);
      wr_ctrl   = bus_we && (bus_addr == 3'd5);
      swap_req  = wr_ctrl && bus_wdata[1];
      // Display blanks one update after enable is cleared, so look at the incoming value
      en_next   = wr_ctrl ? bus_wdata[0] : enable;
      wrap      = enable && (col_p0 == 2'd3) && (cnt_p0 == '1);
      swap_done = swap_pending && (wrap || !enable);
   end

   // Stage p0: control, scan position and buffers
   always_ff @(posedge clk12MHz or posedge rst) begin
      if (rst) begin
         enable       <= 1'b1;
         swap_pending <= 1'b0;
         frame_done   <= 1'b0;
         col_p0       <= 2'd0;
         cnt_p0       <= '0;
         for (int i = 0; i < 4; i++) begin
            back_buf[i]  <= 8'h00;
            front_buf[i] <= 8'h00;
         end
      end else begin
         if (wr_ctrl) enable <= bus_wdata[0];
         frame_done <= swap_done;
         // A request landing on the swap edge stays queued for the following wrap
         if (swap_done)     swap_pending <= swap_req;
         else if (swap_req) swap_pending <= 1'b1;

         if (!enable) begin
            col_p0 <= 2'd0;
            cnt_p0 <= '0;
         end else begin
            cnt_p0 <= cnt_p0 + DWELL_BITS'(1);
            if (cnt_p0 == '1) col_p0 <= col_p0 + 2'd1;
         end

         if (swap_done) begin
            for (int i = 0; i < 4; i++) front_buf[i] <= back_buf[i];
         end
         if (wr_col) back_buf[bus_addr[1:0]] <= bus_wdata;
      end
   end

   // Stage p1: registered column/row drive
   always_ff @(posedge clk12MHz or posedge rst) begin
      if (rst) begin
         leds    <= 8'h00;
         lcol    <= 4'b1111;
         cur_col <= 2'd0;
      end else if (!en_next) begin
         leds    <= 8'h00;
         lcol    <= 4'b1111;
         cur_col <= 2'd0;
      end else if (cnt_p0 == '0) begin
         leds    <= 8'h00;
         lcol    <= 4'b1111;
         cur_col <= col_p0;
      end else begin
         leds    <= front_buf[col_p0] & {8{gate}};
         lcol    <= ~(4'b0001 << col_p0);
         cur_col <= col_p0;
      end
   end

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Scoreboard bench for led_scan_ctrl (DWELL_BITS=4): stimulus queues timed expectations, monitor compares.
module tb_led_scan_ctrl;

   localparam int F_LEDS = 0;
   localparam int F_LCOL = 1;
   localparam int F_CC   = 2;
   localparam int F_SP   = 3;
   localparam int F_FD   = 4;

   logic       clk12MHz = 1'b0;
   logic       rst = 1'b1;
   logic       bus_we = 1'b0;
   logic [2:0] bus_addr = 3'd0;
   logic [7:0] bus_wdata = 8'h00;
   logic [7:0] leds;
   logic [3:0] lcol;
   logic [1:0] cur_col;
   logic       swap_pending;
   logic       frame_done;

   led_scan_ctrl #(.DWELL_BITS(4)) dut (
      .clk12MHz     (clk12MHz),
      .rst          (rst),
      .bus_we       (bus_we),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .leds         (leds),
      .lcol         (lcol),
      .cur_col      (cur_col),
      .swap_pending (swap_pending),
      .frame_done   (frame_done)
   );

   always #5 clk12MHz = ~clk12MHz;

   int cyc = 0;
   always @(posedge clk12MHz) cyc <= cyc + 1;

   typedef struct {
      int         at;
      int         fld;
      logic [7:0] val;
   } chk_t;

   chk_t q[$];
   int   n_run  = 0;
   int   n_fail = 0;

   function automatic logic [7:0] actual(int fld);
      case (fld)
         F_LEDS:  return leds;
         F_LCOL:  return {4'h0, lcol};
         F_CC:    return {6'h00, cur_col};
         F_SP:    return {7'h00, swap_pending};
         default: return {7'h00, frame_done};
      endcase
   endfunction

   function automatic string fname(int fld);
      case (fld)
         F_LEDS:  return "leds";
         F_LCOL:  return "lcol";
         F_CC:    return "cur_col";
         F_SP:    return "swap_pending";
         default: return "frame_done";
      endcase
   endfunction

   // Monitor: compares every queued expectation due at this cycle
   always @(negedge clk12MHz) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].at <= cyc) begin
            n_run++;
            if (q[i].at < cyc) begin
               n_fail++;
               $display("FAIL %s missed: due cyc %0d, now cyc %0d", fname(q[i].fld), q[i].at, cyc);
            end else if (actual(q[i].fld) !== q[i].val) begin
               n_fail++;
               $display("FAIL %s at cyc %0d: got %h, expected %h", fname(q[i].fld), cyc,
                        actual(q[i].fld), q[i].val);
            end
            q.delete(i);
         end
      end
   end

   task automatic chk(input int at, input int fld, input logic [7:0] val);
      chk_t c;
      c.at = at; c.fld = fld; c.val = val;
      q.push_back(c);
   endtask

   // Expected drive for scan positions p0..p0+n-1, position p visible at cycle b+p+1
   task automatic span(input int b, input int p0, input int n,
                       input logic [7:0] f0, input logic [7:0] f1,
                       input logic [7:0] f2, input logic [7:0] f3, input int br);
      logic [3:0] lc;
      logic [7:0] fv;
      for (int p = p0; p < p0 + n; p++) begin
         int c;
         int col;
         c   = p % 16;
         col = (p / 16) % 4;
         if (c == 0) begin
            chk(b + p + 1, F_LCOL, 8'h0F);
            chk(b + p + 1, F_LEDS, 8'h00);
         end else begin
            lc = ~(4'b0001 << col);
            case (col)
               0: fv = f0;
               1: fv = f1;
               2: fv = f2;
               default: fv = f3;
            endcase
            chk(b + p + 1, F_LCOL, {4'h0, lc});
            chk(b + p + 1, F_LEDS, (c <= br) ? fv : 8'h00);
            chk(b + p + 1, F_CC, 8'(col));
         end
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk12MHz);
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(negedge clk12MHz);
      bus_we = 1'b0;
   endtask

   int base, base2, base3, br;

   initial begin
`ifdef LED_SCAN_PWM_EN
      br = 3;
`else
      br = 15;
`endif
      @(negedge clk12MHz);
      for (int t = 2; t <= 3; t++) begin
         chk(t, F_LEDS, 8'h00); chk(t, F_LCOL, 8'h0F); chk(t, F_CC, 8'h00);
         chk(t, F_SP, 8'h00);   chk(t, F_FD, 8'h00);
      end
      wait_until(4);
      rst  = 1'b0;
      base = 4;

      // Idle scan with empty front buffer
      span(base, 0, 128, 8'h00, 8'h00, 8'h00, 8'h00, 15);
      chk(base + 64, F_FD, 8'h00);
      chk(base + 64, F_SP, 8'h00);

      // First swap
      chk(base + 84, F_SP, 8'h00);
      chk(base + 85, F_SP, 8'h01);
      chk(base + 127, F_SP, 8'h01);
      chk(base + 127, F_FD, 8'h00);
      chk(base + 128, F_SP, 8'h00);
      chk(base + 128, F_FD, 8'h01);
      chk(base + 129, F_FD, 8'h00);
      span(base, 128, 64, 8'h01, 8'h02, 8'h04, 8'h08, 15);
      wait_until(base + 80);
      wr(3'd0, 8'h01); wr(3'd1, 8'h02); wr(3'd2, 8'h04); wr(3'd3, 8'h08);
      wr(3'd5, 8'h03);

      // Swap request exactly on the wrap cycle
      span(base, 192, 64, 8'h01, 8'h02, 8'h04, 8'h08, 15);
      span(base, 256, 64, 8'h10, 8'h20, 8'h40, 8'h80, 15);
      chk(base + 192, F_SP, 8'h01);
      chk(base + 192, F_FD, 8'h00);
      chk(base + 255, F_SP, 8'h01);
      chk(base + 256, F_SP, 8'h00);
      chk(base + 256, F_FD, 8'h01);
      chk(base + 257, F_FD, 8'h00);
      wait_until(base + 150);
      wr(3'd0, 8'h10); wr(3'd1, 8'h20); wr(3'd2, 8'h40); wr(3'd3, 8'h80);
      wait_until(base + 191);
      wr(3'd5, 8'h03);

      // Back-buffer write on the swap edge
      span(base, 320, 64, 8'h10, 8'h20, 8'h55, 8'h80, 15);
      chk(base + 320, F_FD, 8'h01);
      span(base, 384, 36, 8'h10, 8'h20, 8'hFF, 8'h80, 15);
      chk(base + 384, F_FD, 8'h01);
      wait_until(base + 260);
      wr(3'd5, 8'h03);
      wait_until(base + 262);
      wr(3'd2, 8'h55);
      wait_until(base + 319);
      wr(3'd2, 8'hFF);
      wait_until(base + 330);
      wr(3'd5, 8'h03);

      // Disable mid-column 2, swap while disabled, then re-enable
      for (int t = base + 421; t <= base + 441; t++) begin
         chk(t, F_LCOL, 8'h0F);
         chk(t, F_LEDS, 8'h00);
         if (t >= base + 422) chk(t, F_CC, 8'h00);
      end
      chk(base + 433, F_SP, 8'h01);
      chk(base + 433, F_FD, 8'h00);
      chk(base + 434, F_SP, 8'h00);
      chk(base + 434, F_FD, 8'h01);
      chk(base + 435, F_FD, 8'h00);
      base2 = base + 441;
      span(base2, 0, 64, 8'hFF, 8'h20, 8'hFF, 8'h80, br);
      chk(base2 + 64, F_FD, 8'h01);
      span(base2, 64, 35, 8'hFF, 8'h20, 8'hFF, 8'h80, br);
      chk(base2 + 99, F_SP, 8'h01);
      wait_until(base + 420);
      wr(3'd5, 8'h00);
      wait_until(base + 431);
      wr(3'd0, 8'hFF);
      wr(3'd5, 8'h02);
      wait_until(base + 436);
      wr(3'd4, 8'h03);
      wr(3'd6, 8'hAA);
      wr(3'd7, 8'h55);
      wait_until(base + 440);
      wr(3'd5, 8'h01);

      // Swap after aliased-address writes, then reset discards a pending swap
      wait_until(base2 + 10);
      wr(3'd5, 8'h03);
      wait_until(base2 + 70);
      wr(3'd1, 8'h33);
      wr(3'd5, 8'h03);
      chk(base2 + 101, F_SP, 8'h00);
      chk(base2 + 101, F_LEDS, 8'h00);
      chk(base2 + 101, F_LCOL, 8'h0F);
      chk(base2 + 101, F_CC, 8'h00);
      chk(base2 + 101, F_FD, 8'h00);
      wait_until(base2 + 100);
      rst = 1'b1;
      wait_until(base2 + 103);
      rst   = 1'b0;
      base3 = base2 + 103;
      chk(base3 + 2, F_LCOL, 8'h0E);
      chk(base3 + 2, F_LEDS, 8'h00);
      chk(base3 + 30, F_SP, 8'h00);
      chk(base3 + 64, F_SP, 8'h00);
      chk(base3 + 64, F_FD, 8'h00);
      chk(base3 + 65, F_FD, 8'h00);
      wait_until(base3 + 80);
      @(negedge clk12MHz);

      foreach (q[i]) begin
         n_run++;
         n_fail++;
         $display("FAIL %s never checked: due cyc %0d", fname(q[i].fld), q[i].at);
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
